// File: rtl/fflags_queue_ctrl.sv
// fflags_queue_ctrl: in-order queue controller for the floating-point exception-flag RAM.
// The FP writeback path enqueues per-instruction flags. Commit dequeues them in the same
// order, and the committed flags are ORed into the sticky architectural fflags register.
// Optional build macro: FFLAGS_QUEUE_BYPASS_EN. When it is defined, an empty queue passes
// enq_flags straight through to the dequeue side in the same cycle.
module fflags_queue_ctrl #(
  parameter int unsigned DEPTH   = 5,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned FLAGS_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [FLAGS_W-1:0] enq_flags,
  output logic               deq_valid,
  input  logic               deq_ready,
  output logic [FLAGS_W-1:0] deq_flags,
  input  logic               flush,
  input  logic               csr_wr_en,
  input  logic [FLAGS_W-1:0] csr_wr_data,
  output logic [FLAGS_W-1:0] fflags_acc,
  output logic [ADDR_W-1:0]  count,
  output logic [ADDR_W-1:0]  ram_W0_addr,
  output logic               ram_W0_en,
  output logic [FLAGS_W-1:0] ram_W0_data,
  output logic [ADDR_W-1:0]  ram_R0_addr,
  output logic               ram_R0_en,
  input  logic [FLAGS_W-1:0] ram_R0_data
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FullCnt = ADDR_W'(DEPTH);

  logic [ADDR_W-1:0]  head_q, head_d;
  logic [ADDR_W-1:0]  tail_q, tail_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic [FLAGS_W-1:0] acc_q, acc_d;

  logic q_valid;     // the queue itself holds a presentable head entry
  logic byp_active;  // the empty queue forwards enq_flags to the dequeue side
  logic byp_take;    // the forwarded entry is consumed directly and never stored
  logic enq_fire;    // the entry is written into the RAM
  logic q_deq_fire;  // the head entry is popped from the RAM
  logic deq_fire;    // commit consumes an entry, from either the RAM or the bypass

  // Steps a pointer forward, wrapping DEPTH-1 back to 0 so non-power-of-2 depths work.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
    return (ptr == LastIdx) ? '0 : ptr + ADDR_W'(1);
  endfunction

`ifdef FFLAGS_QUEUE_BYPASS_EN
  assign byp_active = (count_q == '0) && enq_valid && !flush;
`else
  assign byp_active = 1'b0;
`endif

  // Derives the handshakes and their fire conditions. Flush masks both sides.
  always_comb begin
    q_valid    = (count_q != '0) && !flush;
    enq_ready  = (count_q != FullCnt) && !flush;
    deq_valid  = q_valid || byp_active;
    byp_take   = byp_active && deq_ready;
    enq_fire   = enq_valid && enq_ready && !byp_take;
    q_deq_fire = q_valid && deq_ready;
    deq_fire   = deq_valid && deq_ready;
  end

  // Drives the dequeue data. Undefined RAM data is masked whenever the read is disabled.
  always_comb begin
    deq_flags = '0;
    if (byp_active) begin
      deq_flags = enq_flags;
    end else if (q_valid) begin
      deq_flags = ram_R0_data;
    end
  end

  // Drives the RAM ports. The write port is idle unless an enqueue fires.
  always_comb begin
    ram_W0_en   = enq_fire;
    ram_W0_addr = enq_fire ? tail_q : '0;
    ram_W0_data = enq_fire ? enq_flags : '0;
    ram_R0_en   = q_valid;
    ram_R0_addr = head_q;
  end

  // Computes the pointer and occupancy next state. Flush returns the queue to empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d = ptr_inc(tail_q);
      end
      if (q_deq_fire) begin
        head_d = ptr_inc(head_q);
      end
      unique case ({enq_fire, q_deq_fire})
        2'b10:   count_d = count_q + ADDR_W'(1);
        2'b01:   count_d = count_q - ADDR_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Computes the sticky flags. A CSR write replaces the value, but a same-cycle commit
  // is still merged in so that its flags are not lost.
  always_comb begin
    acc_d = acc_q;
    if (csr_wr_en) begin
      acc_d = csr_wr_data | (deq_fire ? deq_flags : '0);
    end else if (deq_fire) begin
      acc_d = acc_q | deq_flags;
    end
  end

  // Holds the state registers. Reset is asynchronous and active-low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  assign count      = count_q;
  assign fflags_acc = acc_q;

endmodule

// File: tb/tb_fflags_queue_ctrl.sv
// tb_fflags_queue_ctrl: directed, self-checking bench for fflags_queue_ctrl.
// It models the attached RAM and compares the DUT against hand-computed expectations.
// Both builds are covered: the test of an empty queue follows FFLAGS_QUEUE_BYPASS_EN.
module tb_fflags_queue_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enq_valid, enq_ready;
  logic [4:0] enq_flags;
  logic       deq_valid, deq_ready;
  logic [4:0] deq_flags;
  logic       flush, csr_wr_en;
  logic [4:0] csr_wr_data, fflags_acc;
  logic [2:0] count;
  logic [2:0] ram_W0_addr, ram_R0_addr;
  logic       ram_W0_en, ram_R0_en;
  logic [4:0] ram_W0_data, ram_R0_data;

  int n_total = 0;
  int n_bad   = 0;

  logic [4:0] mem [0:7];
  logic [4:0] sb [$];
  int         tp, hp;
  logic [4:0] v;

  always #5 clock = ~clock;

  // RAM model. The read data is garbage when disabled, which exposes any leak.
  always_ff @(posedge clock) begin
    if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
  end
  assign ram_R0_data = ram_R0_en ? mem[ram_R0_addr] : 5'h1f;

  fflags_queue_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_flags   (enq_flags),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_flags   (deq_flags),
    .flush       (flush),
    .csr_wr_en   (csr_wr_en),
    .csr_wr_data (csr_wr_data),
    .fflags_acc  (fflags_acc),
    .count       (count),
    .ram_W0_addr (ram_W0_addr),
    .ram_W0_en   (ram_W0_en),
    .ram_W0_data (ram_W0_data),
    .ram_R0_addr (ram_R0_addr),
    .ram_R0_en   (ram_R0_en),
    .ram_R0_data (ram_R0_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 5'h00;
    reset_n = 1'b0; enq_valid = 1'b0; enq_flags = 5'h00; deq_ready = 1'b0;
    flush = 1'b0; csr_wr_en = 1'b0; csr_wr_data = 5'h00;
    #12;
    check("rst_count", count, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_deq_flags", deq_flags, 0);
    check("rst_acc", fflags_acc, 0);
    check("rst_w_en", ram_W0_en, 0);
    check("rst_r_en", ram_R0_en, 0);
    check("rst_w_addr", ram_W0_addr, 0);
    check("rst_r_addr", ram_R0_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Fill the queue to capacity.
    for (int i = 0; i < 5; i++) begin
      enq_valid = 1'b1; enq_flags = 5'(1 << i);
      #1;
      check("fill_w_en", ram_W0_en, 1);
      check("fill_w_addr", ram_W0_addr, i);
      check("fill_w_data", ram_W0_data, 1 << i);
      tick();
    end
    check("full_count", count, 5);
    check("full_enq_ready", enq_ready, 0);
    enq_flags = 5'h1f;
    #1;
    check("full_no_write", ram_W0_en, 0);
    tick();
    check("full_count_hold", count, 5);

    // Drain the full queue.
    enq_valid = 1'b0; deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("drain_valid", deq_valid, 1);
      check("drain_r_addr", ram_R0_addr, i);
      check("drain_flags", deq_flags, 1 << i);
      tick();
    end
    check("drain_acc", fflags_acc, 5'h1f);
    check("drain_count", count, 0);
    check("drain_deq_valid", deq_valid, 0);

    // Continuous stream at occupancy 2, with the pointers wrapping.
    deq_ready = 1'b0; enq_valid = 1'b1;
    enq_flags = 5'h11; sb.push_back(5'h11); tick();
    enq_flags = 5'h12; sb.push_back(5'h12); tick();
    tp = 2; hp = 0;
    deq_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v = 5'(i * 7 + 3);
      enq_flags = v;
      #1;
      check("strm_w_en", ram_W0_en, 1);
      check("strm_w_addr", ram_W0_addr, tp);
      check("strm_r_addr", ram_R0_addr, hp);
      check("strm_flags", deq_flags, sb[0]);
      tick();
      void'(sb.pop_front());
      sb.push_back(v);
      tp = (tp + 1) % 5;
      hp = (hp + 1) % 5;
      check("strm_count", count, 2);
    end

    // Reach occupancy 3, then flush together with an enqueue and a CSR write.
    deq_ready = 1'b0; enq_flags = 5'h15;
    tick();
    check("pre_flush_count", count, 3);
    flush = 1'b1; enq_valid = 1'b1; csr_wr_en = 1'b1; csr_wr_data = 5'h04; deq_ready = 1'b1;
    #1;
    check("flush_no_write", ram_W0_en, 0);
    check("flush_deq_valid", deq_valid, 0);
    check("flush_enq_ready", enq_ready, 0);
    tick();
    flush = 1'b0; enq_valid = 1'b0; csr_wr_en = 1'b0; deq_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_acc", fflags_acc, 5'h04);

    // A CSR write in the same cycle as a commit keeps the committed flags.
    csr_wr_en = 1'b1; csr_wr_data = 5'h03;
    tick();
    csr_wr_en = 1'b0;
    check("csr_set_acc", fflags_acc, 5'h03);
    enq_valid = 1'b1; enq_flags = 5'h10;
    #1;
    check("csr_enq_addr", ram_W0_addr, 0);
    tick();
    enq_valid = 1'b0;
    csr_wr_en = 1'b1; csr_wr_data = 5'h00; deq_ready = 1'b1;
    #1;
    check("csr_deq_flags", deq_flags, 5'h10);
    tick();
    csr_wr_en = 1'b0; deq_ready = 1'b0;
    check("csr_deq_acc", fflags_acc, 5'h10);
    check("csr_deq_count", count, 0);

    // Enqueue into an empty queue while commit is ready.
    enq_valid = 1'b1; enq_flags = 5'h08; deq_ready = 1'b1;
    #1;
`ifdef FFLAGS_QUEUE_BYPASS_EN
    check("byp_deq_valid", deq_valid, 1);
    check("byp_deq_flags", deq_flags, 5'h08);
    check("byp_no_write", ram_W0_en, 0);
    tick();
    enq_valid = 1'b0;
    check("byp_acc", fflags_acc, 5'h18);
    check("byp_count", count, 0);
`else
    check("nobyp_deq_valid", deq_valid, 0);
    check("nobyp_write", ram_W0_en, 1);
    tick();
    enq_valid = 1'b0;
    #1;
    check("nobyp_next_valid", deq_valid, 1);
    check("nobyp_next_flags", deq_flags, 5'h08);
    tick();
    check("nobyp_acc", fflags_acc, 5'h18);
    check("nobyp_count", count, 0);
`endif
    deq_ready = 1'b0;

    // An asynchronous reset mid-operation clears the state at once.
    enq_valid = 1'b1; enq_flags = 5'h01;
    tick();
    enq_valid = 1'b0;
    check("pre_rst_count", count, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_acc", fflags_acc, 0);
    check("async_rst_deq_valid", deq_valid, 0);
    #3;
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
